tree_node_gather: RTL and testbench

- Fan-in counterpart to the fan-out hierarchy node.
- Collects result beats from NUM_CHILD child instances over per-child valid/ready streams and arbitrates them round-robin.
- Buffers accepted beats in a 2-entry output FIFO and emits one tagged stream (data plus child index) toward the parent.
- Sits at each hierarchy level so the results of a subtree return upward over a single interface.

---
 rtl/tree_node_gather.sv | 157 +++++++++++++++
 tb/tb_tree_node_gather.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tree_node_gather.sv
// Fan-in hierarchy node: round-robin gathers NUM_CHILD child streams into a 2-entry FIFO
// and emits one {idx, data} stream upward. Define TREE_NODE_GATHER_PARITY_EN to add m_par.
module tree_node_gather #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        c_valid,
  output logic [NUM_CHILD-1:0]        c_ready,
  input  logic [NUM_CHILD*DATA_W-1:0] c_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [IDX_W-1:0]            m_idx,
  output logic [31:0]                 beat_cnt
`ifdef TREE_NODE_GATHER_PARITY_EN
  ,
  output logic                        m_par
`endif
);

  logic [1:0]        count_q, count_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [IDX_W-1:0]  head_idx_q, head_idx_d, tail_idx_q, tail_idx_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
`ifdef TREE_NODE_GATHER_PARITY_EN
  logic              head_par_q, head_par_d, tail_par_q, tail_par_d;
  logic              push_par;
`endif

  logic              space;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  int                sum;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;

  // Round-robin scan starting at rr_ptr; rst gates every handshake off.
  always_comb begin
    space       = (count_q < 2'd2);
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sum         = 0;
    c_ready     = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NUM_CHILD) sum = sum - NUM_CHILD;
      cand = IDX_W'(sum);
      if (!grant_found && c_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_found && space && !rst) c_ready[grant_idx] = 1'b1;
  end

  assign m_valid   = (count_q != 2'd0) && !rst;
  assign m_data    = head_data_q;
  assign m_idx     = head_idx_q;
  assign beat_cnt  = beat_cnt_q;
  assign push      = |c_ready;
  assign pop       = m_valid && m_ready;
  assign push_data = c_data[grant_idx*DATA_W +: DATA_W];
`ifdef TREE_NODE_GATHER_PARITY_EN
  assign push_par  = ^{grant_idx, push_data};
  assign m_par     = head_par_q;
`endif

  always_comb begin
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    head_data_d = head_data_q;
    head_idx_d  = head_idx_q;
    tail_data_d = tail_data_q;
    tail_idx_d  = tail_idx_q;
    beat_cnt_d  = beat_cnt_q + 32'(pop);
`ifdef TREE_NODE_GATHER_PARITY_EN
    head_par_d  = head_par_q;
    tail_par_d  = tail_par_q;
`endif
    if (push) begin
      if (grant_idx == IDX_W'(NUM_CHILD - 1)) rr_ptr_d = '0;
      else                                     rr_ptr_d = grant_idx + IDX_W'(1);
    end
    // Head holds its last value when the FIFO drains to empty.
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_data_d = push_data;
          head_idx_d  = grant_idx;
`ifdef TREE_NODE_GATHER_PARITY_EN
          head_par_d  = push_par;
`endif
        end else begin
          tail_data_d = push_data;
          tail_idx_d  = grant_idx;
`ifdef TREE_NODE_GATHER_PARITY_EN
          tail_par_d  = push_par;
`endif
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_idx_d  = tail_idx_q;
`ifdef TREE_NODE_GATHER_PARITY_EN
          head_par_d  = tail_par_q;
`endif
        end
      end
      2'b11: begin
        head_data_d = push_data;
        head_idx_d  = grant_idx;
`ifdef TREE_NODE_GATHER_PARITY_EN
        head_par_d  = push_par;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      rr_ptr_q    <= '0;
      head_data_q <= '0;
      head_idx_q  <= '0;
      tail_data_q <= '0;
      tail_idx_q  <= '0;
      beat_cnt_q  <= '0;
`ifdef TREE_NODE_GATHER_PARITY_EN
      head_par_q  <= 1'b0;
      tail_par_q  <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      head_data_q <= head_data_d;
      head_idx_q  <= head_idx_d;
      tail_data_q <= tail_data_d;
      tail_idx_q  <= tail_idx_d;
      beat_cnt_q  <= beat_cnt_d;
`ifdef TREE_NODE_GATHER_PARITY_EN
      head_par_q  <= head_par_d;
      tail_par_q  <= tail_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_tree_node_gather.sv
// Scoreboard bench for tree_node_gather: a reference model predicts grants, FIFO
// occupancy and beat count; accepted beats are queued and compared at the output.
module tb_tree_node_gather;

  localparam int NC = 5;
  localparam int DW = 16;
  localparam int IW = 3;

  logic             clk;
  logic             rst;
  logic [NC-1:0]    c_valid;
  logic [NC-1:0]    c_ready;
  logic [NC*DW-1:0] c_data;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic [IW-1:0]    m_idx;
  logic [31:0]      beat_cnt;
`ifdef TREE_NODE_GATHER_PARITY_EN
  logic             m_par;
`endif

  tree_node_gather #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_data   (c_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_idx    (m_idx),
    .beat_cnt (beat_cnt)
`ifdef TREE_NODE_GATHER_PARITY_EN
    ,
    .m_par    (m_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun   = 0;
  int testsFailed = 0;

  // Reference model state
  logic [DW-1:0]   cData [NC];
  logic [IW+DW-1:0] sb [$];
  int              mCount;
  int              mPtr;
  logic [31:0]     mBeat;
  logic [NC-1:0]   lastGrant;
  bit              fairPhase;
  int              fairNext;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCount = 0;
    mPtr   = 0;
    mBeat  = '0;
    sb.delete();
    lastGrant = '0;
  endtask

  task automatic driveInputs(input logic [NC-1:0] valid, input logic ready, input logic rstIn);
    c_valid = valid;
    m_ready = ready;
    rst     = rstIn;
    for (int i = 0; i < NC; i++) c_data[i*DW +: DW] = cData[i];
  endtask

  // One clock of stimulus: inputs set, model checked at negedge, model advanced after posedge.
  task automatic applyStimulus(input logic [NC-1:0] valid, input logic ready, input logic rstIn);
    logic [NC-1:0]    expGrant;
    int               gi;
    bit               doPush, doPop;
    logic [IW+DW-1:0] e;
    driveInputs(valid, ready, rstIn);
    @(negedge clk);
    expGrant = '0;
    gi = 0;
    doPush = 0;
    doPop  = 0;
    if (rstIn) begin
      checkOutput("rst_c_ready", 32'(c_ready), 32'h0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'h0);
    end else begin
      if (mCount < 2) begin
        for (int off = NC - 1; off >= 0; off--) begin
          if (valid[(mPtr + off) % NC]) gi = (mPtr + off) % NC;
        end
        if (valid != '0) expGrant[gi] = 1'b1;
      end
      checkOutput("c_ready", 32'(c_ready), 32'(expGrant));
      checkOutput("m_valid", 32'(m_valid), 32'(mCount != 0));
      checkOutput("beat_cnt", beat_cnt, mBeat);
      doPop  = (mCount != 0) && ready;
      doPush = (expGrant != '0);
      if (doPop) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("m_data", 32'(m_data), 32'(e[DW-1:0]));
          checkOutput("m_idx", 32'(m_idx), 32'(e[IW+DW-1:DW]));
`ifdef TREE_NODE_GATHER_PARITY_EN
          checkOutput("m_par", 32'(m_par), 32'(^e));
`endif
          if (fairPhase) begin
            checkOutput("rr_order", 32'(m_idx), 32'(fairNext));
            fairNext = (fairNext + 1) % NC;
          end
        end
      end
      if (doPush) sb.push_back({IW'(gi), cData[gi]});
    end
    @(posedge clk);
    #1;
    if (rstIn) begin
      modelReset();
    end else begin
      mCount = mCount + int'(doPush) - int'(doPop);
      if (doPop) mBeat = mBeat + 32'd1;
      if (doPush) begin
        mPtr = (gi + 1) % NC;
        cData[gi] = cData[gi] + 16'h0100;
      end
      lastGrant = expGrant;
    end
  endtask

  task automatic runIdle(input int n, input logic ready);
    for (int i = 0; i < n; i++) applyStimulus('0, ready, 1'b0);
  endtask

  initial begin
    logic [NC-1:0] rv;
    fairPhase = 0;
    fairNext  = 0;
    for (int i = 0; i < NC; i++) cData[i] = 16'h0000;
    modelReset();
    driveInputs('0, 1'b0, 1'b1);

    // Reset and idle
    applyStimulus('0, 1'b0, 1'b1);
    runIdle(10, 1'b0);

    // Single beat from child 3
    cData[3] = 16'h00A5;
    driveInputs(5'b01000, 1'b1, 1'b0);
    #1;
    checkOutput("single_c_ready", 32'(c_ready), 32'h08);
    applyStimulus(5'b01000, 1'b1, 1'b0);
    #1;
    checkOutput("single_m_data", 32'(m_data), 32'h00A5);
    checkOutput("single_m_idx", 32'(m_idx), 32'd3);
    runIdle(2, 1'b1);
    checkOutput("single_beat_cnt", beat_cnt, 32'd1);

    // Round-robin fairness, all children valid
    applyStimulus('0, 1'b1, 1'b1);
    for (int i = 0; i < NC; i++) cData[i] = 16'h1000 + 16'(i);
    fairPhase = 1;
    fairNext  = 0;
    for (int i = 0; i < 20; i++) applyStimulus(5'b11111, 1'b1, 1'b0);
    runIdle(3, 1'b1);
    fairPhase = 0;
    checkOutput("fair_count", 32'(mBeat), 32'd20);

    // Backpressure with children 0 and 1
    applyStimulus('0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(5'b00011, 1'b0, 1'b0);
    driveInputs(5'b00011, 1'b0, 1'b0);
    #1;
    checkOutput("bp_c_ready", 32'(c_ready), 32'h0);
    checkOutput("bp_head_idx", 32'(m_idx), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(5'b00011, 1'b1, 1'b0);

    // Reset with a full FIFO
    for (int i = 0; i < 3; i++) applyStimulus(5'b00011, 1'b0, 1'b0);
    applyStimulus(5'b10100, 1'b0, 1'b1);
    driveInputs(5'b10100, 1'b0, 1'b0);
    #1;
    checkOutput("mid_rst_c_ready", 32'(c_ready), 32'h04);
    checkOutput("mid_rst_m_valid", 32'(m_valid), 32'h0);
    checkOutput("mid_rst_beat_cnt", beat_cnt, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(5'b10100, 1'b1, 1'b0);
    runIdle(3, 1'b1);

    // Random traffic; a child holds valid until accepted
    rv = '0;
    for (int i = 0; i < 300; i++) begin
      rv = (rv & ~lastGrant) | NC'($urandom_range(0, 31));
      applyStimulus(rv, 1'($urandom_range(0, 1)), 1'b0);
    end
    runIdle(4, 1'b1);

`ifdef TREE_NODE_GATHER_PARITY_EN
    // Parity on known beats
    applyStimulus('0, 1'b1, 1'b1);
    cData[2] = 16'h0001;
    applyStimulus(5'b00100, 1'b1, 1'b0);
    #1 checkOutput("par_c2", 32'(m_par), 32'd0);
    runIdle(1, 1'b1);
    cData[1] = 16'h0001;
    applyStimulus(5'b00010, 1'b1, 1'b0);
    #1 checkOutput("par_c1", 32'(m_par), 32'd0);
    runIdle(1, 1'b1);
    cData[0] = 16'h0003;
    applyStimulus(5'b00001, 1'b1, 1'b0);
    #1 checkOutput("par_c0", 32'(m_par), 32'd0);
    runIdle(1, 1'b1);
    cData[4] = 16'h0000;
    applyStimulus(5'b10000, 1'b1, 1'b0);
    #1 checkOutput("par_c4", 32'(m_par), 32'd1);
    runIdle(2, 1'b1);
`endif

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
